mux_par2ser_feeder: RTL and testbench

//   Parallel-to-serial front end for the 4:1 mux datapath. Accepts a WIDTH-bit word over a

---
 rtl/mux_par2ser_feeder.sv | 119 +++++++++++
 tb/tb_mux_par2ser_feeder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_par2ser_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mux_par2ser_feeder
// Description : Parallel-to-serial front end for the 4:1 mux datapath. Holds an
//               accepted word and steps a select index across it, emitting the
//               selected bit as a registered valid/ready serial stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_par2ser_feeder #(
  parameter  int WIDTH     = 4,
  parameter  bit LSB_FIRST = 1'b1,
  localparam int SEL_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] word_out,
  output logic [SEL_W-1:0] sel_out,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [7:0]       frame_cnt
);

  localparam logic [SEL_W-1:0] c_first = LSB_FIRST ? '0 : SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] c_final = LSB_FIRST ? SEL_W'(WIDTH - 1) : '0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_word, w_word_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt, w_sel_step;
  logic             r_ser, w_ser_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_last, w_last_nxt;
  logic [7:0]       r_frame, w_frame_nxt;
  logic             w_consume, w_accept, w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_sel   <= '0;
      r_ser   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_frame <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_sel   <= w_sel_nxt;
      r_ser   <= w_ser_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_sel_nxt   = r_sel;
    w_ser_nxt   = r_ser;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_frame_nxt = r_frame;

    w_consume  = r_valid && ser_ready;
    // A new word may only enter when idle or as the final beat leaves.
    w_ready    = rst_n && ((r_state == ST_IDLE) || (w_consume && r_last));
    w_accept   = in_valid && w_ready;
    w_sel_step = LSB_FIRST ? (r_sel + SEL_W'(1)) : (r_sel - SEL_W'(1));

    case (r_state)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (w_consume) begin
          if (r_last) begin
            w_frame_nxt = r_frame + 8'd1;
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            w_sel_nxt  = w_sel_step;
            w_ser_nxt  = r_word[w_sel_step];
            w_last_nxt = (w_sel_step == c_final);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Loading overrides the drop-to-idle so back-to-back words leave no bubble.
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
      w_word_nxt  = in_data;
      w_sel_nxt   = c_first;
      w_ser_nxt   = in_data[c_first];
      w_valid_nxt = 1'b1;
      w_last_nxt  = 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign word_out  = r_word;
  assign sel_out   = r_sel;
  assign ser_out   = r_ser;
  assign ser_valid = r_valid;
  assign ser_last  = r_last;
  assign frame_cnt = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_mux_par2ser_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_par2ser_feeder
// Description : Scoreboard bench driving LSB-first and MSB-first instances with
//               shared random stimulus; expected beats are queued on accept.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_par2ser_feeder;

  localparam int W = 4;

  typedef struct {
    int sel;
    int b;
    int last;
    int word;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         ser_ready;

  logic         rdy_l, rdy_m;
  logic [W-1:0] word_l, word_m;
  logic [1:0]   sel_l, sel_m;
  logic         ser_l, ser_m, sv_l, sv_m, last_l, last_m;
  logic [7:0]   fc_l, fc_m;

  beat_t q_l[$];
  beat_t q_m[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    frame_exp = 0;
  bit    was_rst  = 1'b0;
  bit    rmode    = 1'b0;

  mux_par2ser_feeder #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .word_out(word_l), .sel_out(sel_l), .ser_out(ser_l), .ser_valid(sv_l),
    .ser_ready(ser_ready), .ser_last(last_l), .frame_cnt(fc_l)
  );

  mux_par2ser_feeder #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .word_out(word_m), .sel_out(sel_m), .ser_out(ser_m), .ser_valid(sv_m),
    .ser_ready(ser_ready), .ser_last(last_m), .frame_cnt(fc_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input string tag, input int qs, input beat_t f,
                          input int word, input int sel, input int ser, input int sv,
                          input int last, input int rdy, input int fc);
    int exp_rdy;
    exp_rdy = ((qs == 0) || (qs == 1 && ser_ready)) ? 1 : 0;
    chk({tag, ".ser_valid"}, sv, (qs > 0) ? 1 : 0);
    chk({tag, ".in_ready"}, rdy, exp_rdy);
    chk({tag, ".frame_cnt"}, fc, frame_exp);
    if (qs > 0) begin
      chk({tag, ".sel_out"}, sel, f.sel);
      chk({tag, ".ser_out"}, ser, f.b);
      chk({tag, ".ser_last"}, last, f.last);
      chk({tag, ".word_out"}, word, f.word);
    end
  endtask

  // Monitor: compares against the queue head, pops on each consumed beat.
  always @(negedge clk) begin
    beat_t fl, fm;
    if (!rst_n) begin
      chk("rst.in_ready_lsb", int'(rdy_l), 0);
      chk("rst.in_ready_msb", int'(rdy_m), 0);
      q_l.delete();
      q_m.delete();
      frame_exp = 0;
      was_rst   = 1'b1;
    end else begin
      if (was_rst) begin
        chk("post_rst.word_lsb", int'(word_l), 0);
        chk("post_rst.sel_lsb", int'(sel_l), 0);
        chk("post_rst.ser_lsb", int'(ser_l), 0);
        chk("post_rst.last_lsb", int'(last_l), 0);
        chk("post_rst.word_msb", int'(word_m), 0);
        chk("post_rst.sel_msb", int'(sel_m), 0);
        was_rst = 1'b0;
      end
      fl = '{0, 0, 0, 0};
      fm = '{0, 0, 0, 0};
      if (q_l.size() > 0) fl = q_l[0];
      if (q_m.size() > 0) fm = q_m[0];
      chk_inst("lsb", q_l.size(), fl, int'(word_l), int'(sel_l), int'(ser_l), int'(sv_l),
               int'(last_l), int'(rdy_l), int'(fc_l));
      chk_inst("msb", q_m.size(), fm, int'(word_m), int'(sel_m), int'(ser_m), int'(sv_m),
               int'(last_m), int'(rdy_m), int'(fc_m));
      if (ser_ready && q_l.size() > 0) begin
        fl = q_l.pop_front();
        if (fl.last != 0) frame_exp = (frame_exp + 1) % 256;
      end
      if (ser_ready && q_m.size() > 0) void'(q_m.pop_front());
    end
  end

  always begin
    @(posedge clk);
    #1;
    ser_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic push_word(input logic [W-1:0] w);
    int s;
    for (int k = 0; k < W; k++) begin
      q_l.push_back('{k, int'(w[k]), (k == W - 1) ? 1 : 0, int'(w)});
      s = W - 1 - k;
      q_m.push_back('{s, int'(w[s]), (k == W - 1) ? 1 : 0, int'(w)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc;
    int t;
    in_valid = 1'b1;
    in_data  = w;
    acc      = 1'b0;
    t        = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_valid && rdy_l && rst_n;
      @(posedge clk);
      #1;
      t++;
    end
    if (acc) push_word(w);
    else chk("send_timeout", 1, 0);
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  initial begin
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hF;
    ser_ready = 1'b1;
    idle(3);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    send(4'b1011);
    idle(3);
    send(4'hA);
    send(4'h5);
    idle(3);

    rmode = 1'b1;
    send(4'b0110);
    idle(8);

    // Abandon a word with sel_out at index 2 (LSB instance).
    rmode = 1'b0;
    send(4'h3);
    idle(2);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h9;
    idle(1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    send(4'hF);
    idle(2);

    rmode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    t = 0;
    while (q_l.size() > 0 && t < 200) begin
      idle(1);
      t++;
    end
    chk("drain_remaining", q_l.size(), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
